// File: rtl/coproc_pkg.sv
// Types and constants shared by command_decoder and the coprocessor execution stage.
package coproc_pkg;

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_SUM = 2'b01,
      CMD_MAX = 2'b10,
      CMD_AVG = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      BCD,
      SEND,
      WAIT_TX
   } exec_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;

   // 10^k for small k; the loop bound is fixed so it unrolls to a mux.
   function automatic logic [31:0] pow10(input int unsigned k);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned i = 0; i < 9; i++) begin
         if (i < k) p = p * 32'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bin2ascii_dec.sv
// Sequential binary-to-ASCII-decimal converter: repeated subtraction of 10^k,
// most significant digit first, one subtraction per cycle.
module bin2ascii_dec
   import coproc_pkg::*;
#(
   parameter int unsigned RES_W      = 10,
   parameter int unsigned NUM_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [RES_W-1:0]        value,
   output logic                    done,
   output logic [NUM_DIGITS*8-1:0] digits
);

   localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic              active_q;
   logic [RES_W-1:0]  rem_q;
   logic [DIG_W-1:0]  idx_q;
   logic [3:0]        cnt_q;
   logic [31:0]       place;
   logic              take;

   always_comb begin
      place = pow10(int'(idx_q));
      take  = (32'(rem_q) >= place);
   end

   // digits[k*8 +: 8] holds the ASCII character for the 10^k position.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         rem_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         done     <= 1'b0;
         digits   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            active_q <= 1'b1;
            rem_q    <= value;
            idx_q    <= DIG_W'(NUM_DIGITS - 1);
            cnt_q    <= '0;
         end else if (active_q) begin
            if (take) begin
               rem_q <= rem_q - RES_W'(place);
               cnt_q <= cnt_q + 4'd1;
            end else begin
               digits[int'(idx_q)*8 +: 8] <= ASCII_ZERO + 8'(cnt_q);
               cnt_q <= '0;
               if (idx_q == '0) begin
                  active_q <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  idx_q <= idx_q - DIG_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/coprocessor_exec.sv
// Coprocessor execution stage: SUM/MAX/AVG over a captured operand array,
// result streamed to the UART transmitter as ASCII decimal plus terminator.
module coprocessor_exec
   import coproc_pkg::*;
#(
   parameter int unsigned ELEM_W     = 8,
   parameter int unsigned N_ELEM     = 3,
   parameter int unsigned RES_W      = 10,
   parameter int unsigned NUM_DIGITS = 3,
   parameter logic [7:0]  TERM_CHAR  = 8'h0A
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               command,
   input  logic [ELEM_W*N_ELEM-1:0] array,
   input  logic                     cmd_valid,
   output logic                     coprocessor_busy,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);
   localparam int unsigned CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;
   localparam int unsigned DW    = RES_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS);
   localparam logic [DW-1:0]    DIVISOR  = DW'(N_ELEM);

   exec_state_t state_q, state_d;

   cmd_t                      cmd_q;
   logic [ELEM_W*N_ELEM-1:0]  ops_q;
   logic [RES_W-1:0]          result_q, result_d;
   logic [RES_W-1:0]          quo_q, rem_q;
   logic [CNT_W-1:0]          div_cnt_q;
   logic                      div_active_q;
   logic [IDX_W-1:0]          byte_idx_q;
   logic                      wait_skip_q;
   logic                      bcd_start_q;
   logic                      tx_start_q;
   logic [7:0]                tx_data_q;

   logic                      capture, result_load, div_start, div_step;
   logic                      send_byte, next_byte;
   logic                      bcd_done;
   logic [NUM_DIGITS*8-1:0]   digits;
   logic [RES_W-1:0]          sum_c;
   logic [ELEM_W-1:0]         max_c, elem;
   logic [DW-1:0]             trial_c;
   logic                      ge_c;
   logic [7:0]                byte_sel;

   always_comb begin
      sum_c = '0;
      max_c = '0;
      elem  = '0;
      for (int unsigned i = 0; i < N_ELEM; i++) begin
         elem  = ops_q[i*ELEM_W +: ELEM_W];
         sum_c = sum_c + RES_W'(elem);
         if (elem > max_c) max_c = elem;
      end
   end

   // Restoring division: the dividend shifts out of quo_q MSB-first while
   // quotient bits shift in at the bottom.
   always_comb begin
      trial_c = {rem_q, quo_q[RES_W-1]};
      ge_c    = (trial_c >= DIVISOR);
   end

   always_comb begin
      byte_sel = TERM_CHAR;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (byte_idx_q == IDX_W'(i)) byte_sel = digits[(NUM_DIGITS-1-i)*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      result_load = 1'b0;
      result_d    = '0;
      div_start   = 1'b0;
      div_step    = 1'b0;
      send_byte   = 1'b0;
      next_byte   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && (command != CMD_NOP)) begin
               capture = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (div_active_q) begin
               div_step = 1'b1;
               if (div_cnt_q == '0) begin
                  result_load = 1'b1;
                  result_d    = {quo_q[RES_W-2:0], ge_c};
                  state_d     = BCD;
               end
            end else begin
               case (cmd_q)
                  CMD_SUM: begin
                     result_load = 1'b1;
                     result_d    = sum_c;
                     state_d     = BCD;
                  end
                  CMD_MAX: begin
                     result_load = 1'b1;
                     result_d    = RES_W'(max_c);
                     state_d     = BCD;
                  end
                  CMD_AVG: div_start = 1'b1;
                  default: state_d = IDLE;
               endcase
            end
         end
         BCD: begin
            if (bcd_done) state_d = SEND;
         end
         SEND: begin
            if (!tx_busy) begin
               send_byte = 1'b1;
               state_d   = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (!wait_skip_q && !tx_busy) begin
               if (byte_idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  next_byte = 1'b1;
                  state_d   = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q        <= CMD_NOP;
         ops_q        <= '0;
         result_q     <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         div_cnt_q    <= '0;
         div_active_q <= 1'b0;
         byte_idx_q   <= '0;
         wait_skip_q  <= 1'b0;
         bcd_start_q  <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'h00;
      end else begin
         tx_start_q  <= send_byte;
         wait_skip_q <= send_byte;
         bcd_start_q <= result_load;
         if (send_byte)   tx_data_q  <= byte_sel;
         if (result_load) result_q   <= result_d;
         if (next_byte)   byte_idx_q <= byte_idx_q + IDX_W'(1);
         if (capture) begin
            cmd_q      <= cmd_t'(command);
            ops_q      <= array;
            byte_idx_q <= '0;
         end
         if (div_start) begin
            quo_q        <= sum_c;
            rem_q        <= '0;
            div_cnt_q    <= CNT_W'(RES_W - 1);
            div_active_q <= 1'b1;
         end else if (div_step) begin
            quo_q     <= {quo_q[RES_W-2:0], ge_c};
            rem_q     <= RES_W'(ge_c ? (trial_c - DIVISOR) : trial_c);
            div_cnt_q <= div_cnt_q - CNT_W'(1);
            if (div_cnt_q == '0) div_active_q <= 1'b0;
         end
      end
   end

   bin2ascii_dec #(
      .RES_W      (RES_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2ascii_dec (
      .clk    (clk),
      .rst    (rst),
      .start  (bcd_start_q),
      .value  (result_q),
      .done   (bcd_done),
      .digits (digits)
   );

   assign coprocessor_busy = (state_q != IDLE);
   assign tx_start         = tx_start_q;
   assign tx_data          = tx_data_q;

endmodule

// File: tb/tb_coprocessor_exec.sv
// Self-checking bench for coprocessor_exec: directed jobs against a behavioural
// byte-stream model, with a responding transmitter of configurable busy time.
module tb_coprocessor_exec;

   logic        clk;
   logic        rst;
   logic [1:0]  command;
   logic [23:0] array;
   logic        cmd_valid;
   logic        coprocessor_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;

   int          checks   = 0;
   int          failures = 0;
   int          busy_len = 2;
   int          rx_count = 0;
   logic [31:0] rx_word  = '0;
   logic [7:0]  last_data = 8'h00;
   logic [7:0]  exp_q[$];
   bit          model_active = 1'b0;

   coprocessor_exec #(
      .ELEM_W     (8),
      .N_ELEM     (3),
      .RES_W      (10),
      .NUM_DIGITS (3),
      .TERM_CHAR  (8'h0A)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .command          (command),
      .array            (array),
      .cmd_valid        (cmd_valid),
      .coprocessor_busy (coprocessor_busy),
      .tx_data          (tx_data),
      .tx_start         (tx_start),
      .tx_busy          (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Expected four-byte stream for one command: three decimal digits + newline.
   function automatic logic [31:0] model_word(input logic [1:0] c, input logic [23:0] a);
      int unsigned e0, e1, e2, v;
      e0 = a[7:0];
      e1 = a[15:8];
      e2 = a[23:16];
      case (c)
         2'b01:   v = e0 + e1 + e2;
         2'b10:   v = (e0 > e1) ? ((e0 > e2) ? e0 : e2) : ((e1 > e2) ? e1 : e2);
         2'b11:   v = (e0 + e1 + e2) / 3;
         default: v = 0;
      endcase
      return {8'(32'h30 + v / 100), 8'(32'h30 + (v / 10) % 10), 8'(32'h30 + v % 10), 8'h0A};
   endfunction

   // Transmitter: busy from the cycle after tx_start for busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && rst) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         last_data = 8'h00;
      end else begin
         if (tx_start) begin
            chk("tx_start_while_tx_busy", {31'd0, tx_busy}, 32'd0);
            chk("tx_start_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            rx_word   = {rx_word[23:0], tx_data};
            rx_count++;
            last_data = tx_data;
         end else begin
            chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_data});
         end
         if (exp_q.size() > 0) chk("busy_during_job", {31'd0, coprocessor_busy}, 32'd1);
      end
   end

   // Called just after a negedge; cmd_valid covers exactly one rising edge.
   task automatic send_cmd(input logic [1:0] c, input logic [23:0] a);
      bit          accept;
      logic [31:0] w;
      accept    = !model_active && (c != 2'b00);
      command   = c;
      array     = a;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (accept) begin
         model_active = 1'b1;
         w = model_word(c, a);
         for (int k = 3; k >= 0; k--) exp_q.push_back(w[k*8 +: 8]);
      end
   endtask

   // Returns at the first negedge with the DUT idle, so the next command
   // lands in the first IDLE cycle.
   task automatic wait_done();
      bit finished;
      finished = 1'b0;
      for (int i = 0; i < 3000 && !finished; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !coprocessor_busy) finished = 1'b1;
      end
      chk("job_done", {31'd0, finished}, 32'd1);
      if (!finished) exp_q.delete();
      model_active = 1'b0;
   endtask

   task automatic run_job(input string name, input logic [1:0] c, input logic [23:0] a,
                          input int bl, input logic [31:0] req);
      int base;
      busy_len = bl;
      base     = rx_count;
      send_cmd(c, a);
      wait_done();
      chk({name, "_count"}, 32'(rx_count - base), 32'd4);
      chk(name, rx_word, req);
   endtask

   task automatic wait_rx(input int target);
      for (int i = 0; i < 2000 && rx_count < target; i++) @(negedge clk);
      chk("rx_reached", {31'd0, rx_count >= target}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      bit  rose;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      command   = 2'b00;
      array     = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, coprocessor_busy}, 32'd0);
      chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
      chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run_job("sum_066", 2'b01, 24'h032A15, 3, 32'h3036360A);
      run_job("max_255", 2'b10, {8'd255, 8'd7, 8'd200}, 2, 32'h3235350A);
      run_job("sum_765", 2'b01, 24'hFFFFFF, 1, 32'h3736350A);
      run_job("avg_255", 2'b11, {8'd255, 8'd255, 8'd255}, 2, 32'h3235350A);
      run_job("avg_000", 2'b11, {8'd1, 8'd1, 8'd0}, 2, 32'h3030300A);
      run_job("avg_001", 2'b11, {8'd0, 8'd1, 8'd4}, 2, 32'h3030310A);

      base = rx_count;
      rose = 1'b0;
      send_cmd(2'b00, 24'h123456);
      repeat (10) begin
         @(negedge clk);
         rose |= coprocessor_busy;
      end
      chk("nop_busy", {31'd0, rose}, 32'd0);
      chk("nop_bytes", 32'(rx_count - base), 32'd0);

      busy_len = 8;
      base     = rx_count;
      send_cmd(2'b10, {8'd99, 8'd100, 8'd9});
      wait_rx(base + 1);
      send_cmd(2'b01, 24'hFFFFFF);
      wait_done();
      chk("max_ignore_count", 32'(rx_count - base), 32'd4);
      chk("max_ignore_100", rx_word, 32'h3130300A);

      run_job("slow_350", 2'b01, {8'd100, 8'd200, 8'd50}, 20, 32'h3335300A);

      busy_len = 5;
      base     = rx_count;
      send_cmd(2'b01, {8'd1, 8'd2, 8'd3});
      wait_rx(base + 2);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset_busy", {31'd0, coprocessor_busy}, 32'd0);
      chk("midreset_tx_start", {31'd0, tx_start}, 32'd0);
      chk("midreset_tx_data", {24'd0, tx_data}, 32'd0);
      exp_q.delete();
      model_active = 1'b0;
      repeat (3) @(negedge clk);
      rst  = 1'b1;
      base = rx_count;
      repeat (40) @(negedge clk);
      chk("no_tx_after_reset", 32'(rx_count - base), 32'd0);
      chk("idle_after_reset", {31'd0, coprocessor_busy}, 32'd0);

      run_job("avg_020", 2'b11, {8'd10, 8'd20, 8'd31}, 2, 32'h3032300A);

      for (int i = 0; i < 6; i++) begin
         logic [1:0]  c;
         logic [23:0] a;
         c = 2'($urandom_range(1, 3));
         a = 24'($urandom);
         run_job("rand", c, a, int'($urandom_range(1, 4)), model_word(c, a));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
